gray_binary_decoder: RTL and testbench

- Receive side of the binary-to-Gray path: samples a Gray-coded bus from another clock domain or a mechanical source, synchronizes it, and decodes it to binary.
- Classifies each code change as +1, -1 or illegal, and tracks a signed position count.
- Consumer end for Gray-coded pointers and encoder positions elsewhere in the design.

---
 rtl/gray_binary_decoder.sv | 95 +++++++++
 tb/tb_gray_binary_decoder.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/gray_binary_decoder.sv
// Gray-code receiver: synchronizes an asynchronous Gray bus, decodes it to binary,
// classifies each change as +1 / -1 / illegal and tracks a signed position.
// Optional macro GRAY_ERR_COUNT_EN adds a saturating 8-bit err_cnt output.
module gray_binary_decoder #(
  parameter int WIDTH       = 4,
  parameter int SYNC_STAGES = 2,
  parameter int POS_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] gray_in,
  input  logic             pos_clr,
  output logic [WIDTH-1:0] bin_out,
  output logic             bin_valid,
  output logic             step_up,
  output logic             step_down,
  output logic             code_err,
  output logic [POS_W-1:0] pos_count
`ifdef GRAY_ERR_COUNT_EN
  , output logic [7:0]     err_cnt
`endif
);

  localparam int FILL_W = $clog2(SYNC_STAGES + 2);

  logic [WIDTH-1:0]  sync_q [SYNC_STAGES];
  logic [WIDTH-1:0]  dec_bin;
  logic [WIDTH-1:0]  diff;
  logic              up_d;
  logic              down_d;
  logic              err_d;
  logic [FILL_W-1:0] fill_cnt;

  // Plain flop chain, nothing between stages.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
    end else begin
      sync_q[0] <= gray_in;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  // Bit i of the binary value is the XOR of all Gray bits at or above i.
  always_comb begin
    dec_bin = '0;
    for (int i = 0; i < WIDTH; i++) dec_bin[i] = ^(sync_q[SYNC_STAGES-1] >> i);
  end

  // Classification only once bin_out holds a real sample; the first one is the baseline.
  always_comb begin
    diff   = dec_bin - bin_out;
    up_d   = 1'b0;
    down_d = 1'b0;
    err_d  = 1'b0;
    if (bin_valid) begin
      if (diff == WIDTH'(1))       up_d   = 1'b1;
      else if (diff == '1)         down_d = 1'b1;
      else if (diff != '0)         err_d  = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fill_cnt  <= '0;
      bin_valid <= 1'b0;
      bin_out   <= '0;
      step_up   <= 1'b0;
      step_down <= 1'b0;
      code_err  <= 1'b0;
    end else begin
      if (!bin_valid) fill_cnt <= fill_cnt + FILL_W'(1);
      if (fill_cnt == FILL_W'(SYNC_STAGES)) bin_valid <= 1'b1;
      bin_out   <= dec_bin;
      step_up   <= up_d;
      step_down <= down_d;
      code_err  <= err_d;
    end
  end

  // Clear beats any step detected in the same cycle.
  always_ff @(posedge clk) begin
    if (rst || pos_clr)  pos_count <= '0;
    else if (up_d)       pos_count <= pos_count + POS_W'(1);
    else if (down_d)     pos_count <= pos_count - POS_W'(1);
  end

`ifdef GRAY_ERR_COUNT_EN
  always_ff @(posedge clk) begin
    if (rst || pos_clr)             err_cnt <= '0;
    else if (err_d && err_cnt != '1) err_cnt <= err_cnt + 8'd1;
  end
`endif

endmodule

// File: tb/tb_gray_binary_decoder.sv
// Bench for gray_binary_decoder: vector table, hand-written corner sequences and
// randomized stimulus, all checked against a queue-based reference model.
module tb_gray_binary_decoder;

  localparam int W = 4;
  localparam int S = 2;
  localparam int P = 16;

  logic         clk = 1'b0;
  logic         rst;
  logic [W-1:0] gray_in;
  logic         pos_clr;
  logic [W-1:0] bin_out;
  logic         bin_valid;
  logic         step_up;
  logic         step_down;
  logic         code_err;
  logic [P-1:0] pos_count;
`ifdef GRAY_ERR_COUNT_EN
  logic [7:0]   err_cnt;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  // clock / reset
  always #5 clk = ~clk;

  gray_binary_decoder #(.WIDTH(W), .SYNC_STAGES(S), .POS_W(P)) dut (
    .clk       (clk),
    .rst       (rst),
    .gray_in   (gray_in),
    .pos_clr   (pos_clr),
    .bin_out   (bin_out),
    .bin_valid (bin_valid),
    .step_up   (step_up),
    .step_down (step_down),
    .code_err  (code_err),
    .pos_count (pos_count)
`ifdef GRAY_ERR_COUNT_EN
    , .err_cnt (err_cnt)
`endif
  );

  // reference model: queue of sampled codes, value emerges S+1 edges after sampling
  logic [W-1:0] exp_q[$];
  logic [W-1:0] m_bin;
  logic         m_valid, m_up, m_dn, m_err;
  logic [P-1:0] m_pos;
  logic [7:0]   m_ec;

  function automatic logic [W-1:0] g2b(input logic [W-1:0] g);
    logic [W-1:0] b;
    b = g;
    for (int s = 1; s < W; s++) b = b ^ (g >> s);
    return b;
  endfunction

  function automatic logic [W-1:0] b2g(input logic [W-1:0] b);
    return b ^ (b >> 1);
  endfunction

  always @(posedge clk) begin
    logic [W-1:0] nb;
    logic [W-1:0] d;
    if (rst) begin
      exp_q.delete();
      m_bin = '0; m_valid = 1'b0; m_up = 1'b0; m_dn = 1'b0; m_err = 1'b0;
      m_pos = '0; m_ec = '0;
    end else begin
      exp_q.push_back(gray_in);
      m_up = 1'b0; m_dn = 1'b0; m_err = 1'b0;
      if (exp_q.size() > S) begin
        nb = g2b(exp_q.pop_front());
        if (m_valid) begin
          d = nb - m_bin;
          if (d == 1)                m_up  = 1'b1;
          else if (d == (1 << W) - 1) m_dn  = 1'b1;
          else if (d != 0)           m_err = 1'b1;
        end
        m_bin   = nb;
        m_valid = 1'b1;
      end
      if (pos_clr)    m_pos = '0;
      else if (m_up)  m_pos = m_pos + 1'b1;
      else if (m_dn)  m_pos = m_pos - 1'b1;
      if (pos_clr)                   m_ec = '0;
      else if (m_err && m_ec != 255) m_ec = m_ec + 8'd1;
    end
  end

  // scoreboard helpers
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    check("bin_out",   32'(bin_out),   32'(m_bin));
    check("bin_valid", 32'(bin_valid), 32'(m_valid));
    check("step_up",   32'(step_up),   32'(m_up));
    check("step_down", 32'(step_down), 32'(m_dn));
    check("code_err",  32'(code_err),  32'(m_err));
    check("pos_count", 32'(pos_count), 32'(m_pos));
`ifdef GRAY_ERR_COUNT_EN
    check("err_cnt",   32'(err_cnt),   32'(m_ec));
`endif
  endtask

  // drive a code, optionally with pos_clr in the cycle its step is classified
  task automatic apply_code(input logic [W-1:0] g, input logic clr);
    gray_in = g;
    repeat (S) tick();
    pos_clr = clr;
    tick();
    pos_clr = 1'b0;
  endtask

  task automatic expect_step(input string name, input logic [W-1:0] b, input logic up,
                             input logic dn, input logic err, input logic [P-1:0] pos);
    check({name, ".bin"},  32'(bin_out),   32'(b));
    check({name, ".up"},   32'(step_up),   32'(up));
    check({name, ".dn"},   32'(step_down), 32'(dn));
    check({name, ".err"},  32'(code_err),  32'(err));
    check({name, ".pos"},  32'(pos_count), 32'(pos));
  endtask

  typedef struct {
    logic [W-1:0] g;
    logic [W-1:0] b;
    logic         up;
    logic         dn;
    logic         err;
    logic [P-1:0] pos;
    logic         clr_first;
  } vec_t;

  vec_t vecs[20];

  initial begin
    logic [W-1:0] bb;
    logic [W-1:0] cur;
    int           r;

    for (int i = 0; i < 16; i++) begin
      bb = W'(i + 1);
      vecs[i] = '{g: b2g(bb), b: bb, up: 1'b1, dn: 1'b0, err: 1'b0, pos: P'(i + 1), clr_first: 1'b0};
    end
    vecs[16] = '{g: 4'b1000, b: 4'd15, up: 1'b0, dn: 1'b1, err: 1'b0, pos: 16'hFFFF, clr_first: 1'b1};
    vecs[17] = '{g: 4'b1001, b: 4'd14, up: 1'b0, dn: 1'b1, err: 1'b0, pos: 16'hFFFE, clr_first: 1'b0};
    vecs[18] = '{g: 4'b0001, b: 4'd1,  up: 1'b0, dn: 1'b0, err: 1'b1, pos: 16'hFFFE, clr_first: 1'b0};
    vecs[19] = '{g: 4'b1001, b: 4'd14, up: 1'b0, dn: 1'b0, err: 1'b1, pos: 16'hFFFE, clr_first: 1'b0};

    rst = 1'b1; gray_in = '0; pos_clr = 1'b0;
    tick(); tick();
    check("reset.bin_out", 32'(bin_out), 32'd0);
    check("reset.pos",     32'(pos_count), 32'd0);
    rst = 1'b0;
    tick(); check("fill.valid1", 32'(bin_valid), 32'd0);
    tick(); check("fill.valid2", 32'(bin_valid), 32'd0);
    tick(); check("fill.valid3", 32'(bin_valid), 32'd1);
    expect_step("baseline0", 4'd0, 1'b0, 1'b0, 1'b0, 16'd0);
    tick();

    // table: full up-count with wrap, then downs and illegal jumps
    for (int i = 0; i < 20; i++) begin
      if (vecs[i].clr_first) begin
        pos_clr = 1'b1; tick(); pos_clr = 1'b0;
        check("tbl.clr", 32'(pos_count), 32'd0);
      end
      apply_code(vecs[i].g, 1'b0);
      expect_step($sformatf("tbl%0d", i), vecs[i].b, vecs[i].up, vecs[i].dn, vecs[i].err, vecs[i].pos);
      tick();
    end
`ifdef GRAY_ERR_COUNT_EN
    check("err_cnt.two", 32'(err_cnt), 32'd2);
`endif

    // pos_clr coinciding with a step: clear wins, pulse still visible
    apply_code(b2g(4'd13), 1'b0); tick();
    apply_code(b2g(4'd12), 1'b0); tick();
    pos_clr = 1'b1; tick(); pos_clr = 1'b0;
    for (int b = 13; b <= 17; b++) begin
      apply_code(b2g(W'(b)), 1'b0); tick();
    end
    check("pre_clr.pos", 32'(pos_count), 32'd5);
    apply_code(b2g(4'd2), 1'b1);
    expect_step("clr_step", 4'd2, 1'b1, 1'b0, 1'b0, 16'd0);
    tick();

    // mid-operation reset with pos_count=7, bin_out=9
    for (int b = 3; b <= 9; b++) begin
      apply_code(b2g(W'(b)), 1'b0); tick();
    end
    expect_step("pre_rst", 4'd9, 1'b0, 1'b0, 1'b0, 16'd7);
    rst = 1'b1; tick();
    expect_step("in_rst", 4'd0, 1'b0, 1'b0, 1'b0, 16'd0);
    check("in_rst.valid", 32'(bin_valid), 32'd0);
    rst = 1'b0;
    tick(); check("refill.valid1", 32'(bin_valid), 32'd0);
    tick(); check("refill.valid2", 32'(bin_valid), 32'd0);
    tick(); check("refill.valid3", 32'(bin_valid), 32'd1);
    expect_step("refill", 4'd9, 1'b0, 1'b0, 1'b0, 16'd0);
    tick();

    // randomized back-to-back changes, clears and rare resets
    cur = 4'd9;
    for (int n = 0; n < 2000; n++) begin
      r = $urandom_range(0, 9);
      if (r <= 3)      cur = cur + 1'b1;
      else if (r <= 5) cur = cur - 1'b1;
      else if (r == 6) cur = W'($urandom_range(0, 15));
      gray_in = b2g(cur);
      pos_clr = ($urandom_range(0, 15) == 0);
      rst     = ($urandom_range(0, 299) == 0);
      tick();
    end
    rst = 1'b0; pos_clr = 1'b0;
    repeat (S + 3) tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
